// File: rtl/zxiznet_top.sv
// Z80 bridge to a W5300 Ethernet controller and an SL811 USB host: IO decode, ROM window
// mapping, control registers and interrupt merge. Define CLOCKED_FILTER_EN to resync chip strobes.
module zxiznet_top (
  input  logic        fclk,
  input  logic        zrst_n,
  input  logic [15:0] za,
  inout  wire  [7:0]  zd,
  input  logic        ziorq_n,
  input  logic        zmreq_n,
  input  logic        zrd_n,
  input  logic        zwr_n,
  input  logic        zcsrom_n,
  output logic        ziorqge,
  output logic        zblkrom,
  output wire         zint_n,
  inout  wire  [7:0]  bd,
  output logic        brd_n,
  output logic        bwr_n,
  output logic        w5300_rst_n,
  output logic        w5300_cs_n,
  output logic [9:0]  w5300_addr,
  input  logic        w5300_int_n,
  output logic        sl811_rst_n,
  output logic        sl811_cs_n,
  output logic        sl811_a0,
  output logic        sl811_ms_n,
  input  logic        sl811_intrq,
  input  logic        usb_power
);

  // ---------------------------------------------------------------------------
  // IO address decode
  // ---------------------------------------------------------------------------
  logic port_ab;
  logic sel_rstint, sel_wcfg, sel_usbctl, sel_sladdr, sel_data, sel_reg;

  assign port_ab    = (za[7:0] == 8'hAB);
  assign sel_rstint = port_ab & (za[15:8] == 8'h83);
  assign sel_wcfg   = port_ab & (za[15:8] == 8'h82);
  assign sel_usbctl = port_ab & (za[15:8] == 8'h81);
  assign sel_sladdr = port_ab & (za[15:8] == 8'h80);
  assign sel_data   = port_ab & ~za[15];
  assign sel_reg    = sel_rstint | sel_wcfg | sel_usbctl;

  assign ziorqge = ~ziorq_n & (sel_reg | sel_sladdr | sel_data);

  // ---------------------------------------------------------------------------
  // Control registers and input synchronisers
  // ---------------------------------------------------------------------------
  logic [7:0] wcfg_q, wcfg_d;
  logic [4:0] rstint_q, rstint_d;  // RSTINT bits [6:2]
  logic       ms_q, ms_d;
  logic [1:0] iowr_s_q, iowr_s_d;
  logic [1:0] wint_s_q, wint_s_d;
  logic [1:0] slint_s_q, slint_s_d;
  logic [1:0] upwr_s_q, upwr_s_d;
  logic       reg_we;

  // Single-cycle pulse on the edge where the synced IO write goes active.
  assign reg_we = iowr_s_q[0] & ~iowr_s_q[1];

  always_comb begin
    iowr_s_d  = {iowr_s_q[0], ~ziorq_n & ~zwr_n};
    wint_s_d  = {wint_s_q[0], ~w5300_int_n};
    slint_s_d = {slint_s_q[0], sl811_intrq};
    upwr_s_d  = {upwr_s_q[0], usb_power};
    wcfg_d    = wcfg_q;
    rstint_d  = rstint_q;
    ms_d      = ms_q;
    if (reg_we) begin
      if (sel_wcfg)   wcfg_d   = zd;
      if (sel_rstint) rstint_d = zd[6:2];
      if (sel_usbctl) ms_d     = zd[0];
    end
  end

  always_ff @(posedge fclk) begin
    if (!zrst_n) begin
      wcfg_q    <= 8'h00;
      rstint_q  <= 5'b00000;
      ms_q      <= 1'b1;
      iowr_s_q  <= 2'b00;
      wint_s_q  <= 2'b00;
      slint_s_q <= 2'b00;
      upwr_s_q  <= 2'b00;
    end else begin
      wcfg_q    <= wcfg_d;
      rstint_q  <= rstint_d;
      ms_q      <= ms_d;
      iowr_s_q  <= iowr_s_d;
      wint_s_q  <= wint_s_d;
      slint_s_q <= slint_s_d;
      upwr_s_q  <= upwr_s_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupts, chip resets and register read-back
  // ---------------------------------------------------------------------------
  logic       wint, slint, irq;
  logic [7:0] rstint_rd, usbctl_rd, reg_rdata;

  assign wint      = wint_s_q[1];
  assign slint     = slint_s_q[1];
  assign irq       = (wint & rstint_q[0]) | (slint & rstint_q[1]);
  assign rstint_rd = {irq, rstint_q, slint, wint};
  assign usbctl_rd = {6'b000000, upwr_s_q[1], ms_q};

  always_comb begin
    reg_rdata = 8'h00;
    if (sel_rstint)      reg_rdata = rstint_rd;
    else if (sel_wcfg)   reg_rdata = wcfg_q;
    else if (sel_usbctl) reg_rdata = usbctl_rd;
  end

  assign w5300_rst_n = rstint_q[2];
  assign sl811_rst_n = rstint_q[3];
  assign sl811_ms_n  = ~ms_q;
  assign zint_n      = (rstint_q[4] & irq) ? 1'b0 : 1'bz;

  // ---------------------------------------------------------------------------
  // ROM window and W5300 address generation
  // ---------------------------------------------------------------------------
  logic        a0_inv, mem_hit;
  logic [13:0] ofs;
  logic [9:0]  win_addr, port_addr;

  assign a0_inv  = wcfg_q[3];
  assign mem_hit = wcfg_q[2] & ~zcsrom_n & (za[15:14] == wcfg_q[1:0]);
  assign zblkrom = mem_hit;
  assign ofs     = za[13:0];

  // Low 8K maps linearly; upper two 4K halves fold onto two fixed register pages.
  always_comb begin
    if (!ofs[13]) begin
      win_addr = ofs[9:0];
    end else if (!ofs[12]) begin
      win_addr = {1'b1, ofs[11:9], 5'b10111, ofs[0]};
    end else begin
      win_addr = {1'b1, ofs[11:9], 5'b11000, ofs[0]};
    end
    win_addr[0] = win_addr[0] ^ a0_inv;
  end

  assign port_addr = {wcfg_q[7:5], za[14:8]} ^ {9'b0, a0_inv};

  // ---------------------------------------------------------------------------
  // Chip strobes
  // ---------------------------------------------------------------------------
  logic       iorq_a, mreq_a, rd_a, wr_a;
  logic       chip_hit_raw;
  logic [7:0] bd_data;

  assign chip_hit_raw = (mem_hit & ~zmreq_n) | ((sel_data | sel_sladdr) & ~ziorq_n);

`ifdef CLOCKED_FILTER_EN
  logic [1:0] iorq_s_q, iorq_s_d;
  logic [1:0] mreq_s_q, mreq_s_d;
  logic [1:0] rd_s_q, rd_s_d;
  logic [1:0] wr_s_q, wr_s_d;
  logic [7:0] wdata_q, wdata_d;

  always_comb begin
    iorq_s_d = {iorq_s_q[0], ~ziorq_n};
    mreq_s_d = {mreq_s_q[0], ~zmreq_n};
    rd_s_d   = {rd_s_q[0], ~zrd_n};
    wr_s_d   = {wr_s_q[0], ~zwr_n};
    // Keep the last write data so bd stays valid while bwr_n trails the Z80 strobe.
    wdata_d  = (chip_hit_raw & ~zwr_n) ? zd : wdata_q;
  end

  always_ff @(posedge fclk) begin
    if (!zrst_n) begin
      iorq_s_q <= 2'b00;
      mreq_s_q <= 2'b00;
      rd_s_q   <= 2'b00;
      wr_s_q   <= 2'b00;
      wdata_q  <= 8'h00;
    end else begin
      iorq_s_q <= iorq_s_d;
      mreq_s_q <= mreq_s_d;
      rd_s_q   <= rd_s_d;
      wr_s_q   <= wr_s_d;
      wdata_q  <= wdata_d;
    end
  end

  assign iorq_a  = iorq_s_q[1];
  assign mreq_a  = mreq_s_q[1];
  assign rd_a    = rd_s_q[1];
  assign wr_a    = wr_s_q[1];
  assign bd_data = wdata_q;
`else
  assign iorq_a  = ~ziorq_n;
  assign mreq_a  = ~zmreq_n;
  assign rd_a    = ~zrd_n;
  assign wr_a    = ~zwr_n;
  assign bd_data = zd;
`endif

  logic w_sel, s_sel, mem_sel;

  assign mem_sel = mem_hit & mreq_a;
  assign w_sel   = mem_sel | (sel_data & wcfg_q[4] & iorq_a);
  assign s_sel   = ((sel_data & ~wcfg_q[4]) | sel_sladdr) & iorq_a;

  assign w5300_cs_n = ~(w_sel & (rd_a | wr_a));
  assign sl811_cs_n = ~(s_sel & (rd_a | wr_a));
  assign brd_n      = ~((w_sel | s_sel) & rd_a);
  assign bwr_n      = ~((w_sel | s_sel) & wr_a);
  assign w5300_addr = mem_sel ? win_addr : port_addr;
  assign sl811_a0   = ~sel_sladdr;

  assign bd = bwr_n ? 8'hzz : bd_data;

  // ---------------------------------------------------------------------------
  // Z80 data bus return path
  // ---------------------------------------------------------------------------
  logic       reg_rd, zd_oe;
  logic [7:0] zd_out;

  assign reg_rd = ~ziorq_n & ~zrd_n & sel_reg;
  assign zd_oe  = reg_rd | (chip_hit_raw & ~zrd_n);
  assign zd_out = reg_rd ? reg_rdata : bd;
  assign zd     = zd_oe ? zd_out : 8'hzz;

endmodule

// File: tb/tb_zxiznet_top.sv
// Bench for zxiznet_top: directed scenarios then randomized bus cycles against a behavioural model.
module tb_zxiznet_top;

  logic        fclk = 1'b0;
  logic        zrst_n;
  logic [15:0] za;
  wire  [7:0]  zd;
  wire  [7:0]  bd;
  wire         zint_n;
  logic        ziorq_n, zmreq_n, zrd_n, zwr_n, zcsrom_n;
  logic        ziorqge, zblkrom, brd_n, bwr_n;
  logic        w5300_rst_n, w5300_cs_n, w5300_int_n;
  logic [9:0]  w5300_addr;
  logic        sl811_rst_n, sl811_cs_n, sl811_a0, sl811_ms_n, sl811_intrq, usb_power;

  logic [7:0]  tb_zd, tb_bd;
  logic        tb_zd_oe, tb_bd_oe;

  assign zd = tb_zd_oe ? tb_zd : 8'hzz;
  assign bd = tb_bd_oe ? tb_bd : 8'hzz;
  pullup (zint_n);

  zxiznet_top dut (
    .fclk        (fclk),
    .zrst_n      (zrst_n),
    .za          (za),
    .zd          (zd),
    .ziorq_n     (ziorq_n),
    .zmreq_n     (zmreq_n),
    .zrd_n       (zrd_n),
    .zwr_n       (zwr_n),
    .zcsrom_n    (zcsrom_n),
    .ziorqge     (ziorqge),
    .zblkrom     (zblkrom),
    .zint_n      (zint_n),
    .bd          (bd),
    .brd_n       (brd_n),
    .bwr_n       (bwr_n),
    .w5300_rst_n (w5300_rst_n),
    .w5300_cs_n  (w5300_cs_n),
    .w5300_addr  (w5300_addr),
    .w5300_int_n (w5300_int_n),
    .sl811_rst_n (sl811_rst_n),
    .sl811_cs_n  (sl811_cs_n),
    .sl811_a0    (sl811_a0),
    .sl811_ms_n  (sl811_ms_n),
    .sl811_intrq (sl811_intrq),
    .usb_power   (usb_power)
  );

  initial forever #5 fclk = ~fclk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int m_wcfg, m_en_w, m_en_sl, m_wrst, m_slrst, m_ext, m_ms;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_wcfg = 0; m_en_w = 0; m_en_sl = 0; m_wrst = 0; m_slrst = 0; m_ext = 0; m_ms = 1;
  endtask

  task automatic m_write(input logic [15:0] a, input logic [7:0] d);
    if (a == 16'h82AB) m_wcfg = int'(d);
    if (a == 16'h83AB) begin
      m_en_w  = int'(d[2]);
      m_en_sl = int'(d[3]);
      m_wrst  = int'(d[4]);
      m_slrst = int'(d[5]);
      m_ext   = int'(d[6]);
    end
    if (a == 16'h81AB) m_ms = int'(d[0]);
  endtask

  function automatic int m_irq();
    int wi, si;
    wi = (w5300_int_n == 1'b0) ? 1 : 0;
    si = (sl811_intrq == 1'b1) ? 1 : 0;
    return ((wi & m_en_w) | (si & m_en_sl));
  endfunction

  function automatic int m_rstint();
    int wi, si;
    wi = (w5300_int_n == 1'b0) ? 1 : 0;
    si = (sl811_intrq == 1'b1) ? 1 : 0;
    return wi + si * 2 + m_en_w * 4 + m_en_sl * 8 + m_wrst * 16 + m_slrst * 32 + m_ext * 64
           + m_irq() * 128;
  endfunction

  function automatic int m_zint();
    return (m_ext == 1 && m_irq() == 1) ? 0 : 1;
  endfunction

  function automatic int exp_win_addr(input int wcfg, input int a);
    int o, r;
    o = a % 'h4000;
    if (o < 'h2000) r = o % 1024;
    else r = 512 + ((o / 512) % 8) * 64 + ((o < 'h3000) ? 'h17 : 'h18) * 2 + (o % 2);
    return r ^ ((wcfg / 8) % 2);
  endfunction

  function automatic int exp_port_addr(input int wcfg, input int a);
    return (((wcfg / 32) % 8) * 128 + (a / 256) % 128) ^ ((wcfg / 8) % 2);
  endfunction

  task automatic bus_start(input bit is_io, input bit is_wr, input logic [15:0] a,
                           input logic [7:0] d);
    @(negedge fclk);
    za = a;
    if (is_wr) begin
      tb_zd = d; tb_zd_oe = 1'b1; zwr_n = 1'b0;
    end else begin
      tb_bd = d; tb_bd_oe = 1'b1; zrd_n = 1'b0;
    end
    if (is_io) ziorq_n = 1'b0;
    else zmreq_n = 1'b0;
    repeat (3) @(negedge fclk);
  endtask

  task automatic bus_end();
    ziorq_n = 1'b1; zmreq_n = 1'b1; zrd_n = 1'b1; zwr_n = 1'b1;
    tb_zd_oe = 1'b0; tb_bd_oe = 1'b0;
    repeat (2) @(negedge fclk);
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
    bus_start(1'b1, 1'b1, a, d);
    bus_end();
    m_write(a, d);
  endtask

  task automatic io_rd(input logic [15:0] a, output logic [7:0] d);
    bus_start(1'b1, 1'b0, a, 8'h00);
    d = zd;
    bus_end();
  endtask

  logic [7:0]  rd, w, d;
  logic [15:0] a;
  bit          wr, hit;

  initial begin
    za = 16'h0000; ziorq_n = 1'b1; zmreq_n = 1'b1; zrd_n = 1'b1; zwr_n = 1'b1;
    zcsrom_n = 1'b1; tb_zd = 8'h00; tb_bd = 8'h00; tb_zd_oe = 1'b0; tb_bd_oe = 1'b0;
    w5300_int_n = 1'b1; sl811_intrq = 1'b0; usb_power = 1'b0;
    zrst_n = 1'b0;
    m_reset();
    repeat (4) @(negedge fclk);
    zrst_n = 1'b1;
    repeat (3) @(negedge fclk);

    // Reset state
    check("rst_w5300_rst_n", w5300_rst_n, 0);
    check("rst_sl811_rst_n", sl811_rst_n, 0);
    check("rst_sl811_ms_n", sl811_ms_n, 0);
    check("rst_zint_n", zint_n, 1);
    check("rst_cs", {w5300_cs_n, sl811_cs_n, brd_n, bwr_n}, 4'hF);
    check("rst_zblkrom", zblkrom, 0);
    io_rd(16'h83AB, rd);
    check("rst_rstint", rd, 8'h00);
    io_rd(16'h82AB, rd);
    check("rst_wcfg", rd, 8'h00);
    io_rd(16'h81AB, rd);
    check("rst_usbctl", rd, 8'h01);

    // Memory window write
    io_wr(16'h82AB, 8'h0E);
    zcsrom_n = 1'b0;
    bus_start(1'b0, 1'b1, 16'h8123, 8'h5A);
    check("win_addr", w5300_addr, 10'h122);
    check("win_bwr_n", bwr_n, 0);
    check("win_cs_n", w5300_cs_n, 0);
    check("win_bd", bd, 8'h5A);
    check("win_zblkrom", zblkrom, 1);
    check("win_ziorqge", ziorqge, 0);
    bus_end();
    check("win_bwr_n_end", bwr_n, 1);
    io_wr(16'h82AB, 8'h0A);
    bus_start(1'b0, 1'b1, 16'h8123, 8'h5A);
    check("nowin_cs_n", {w5300_cs_n, bwr_n}, 2'b11);
    check("nowin_zblkrom", zblkrom, 0);
    bus_end();
    zcsrom_n = 1'b1;

    // W5300 data port read
    io_wr(16'h82AB, 8'hB8);
    bus_start(1'b1, 1'b0, 16'h15AB, 8'h3C);
    check("port_addr", w5300_addr, 10'h294);
    check("port_zd", zd, 8'h3C);
    check("port_strobes", {w5300_cs_n, sl811_cs_n, brd_n}, 3'b010);
    check("port_ziorqge", ziorqge, 1);
    bus_end();

    // SL811 address and data ports
    bus_start(1'b1, 1'b1, 16'h80AB, 8'h77);
    check("sladdr_cs", {sl811_cs_n, sl811_a0, w5300_cs_n}, 3'b001);
    check("sladdr_bd", bd, 8'h77);
    bus_end();
    io_wr(16'h82AB, 8'h00);
    bus_start(1'b1, 1'b0, 16'h42AB, 8'h99);
    check("sldata_cs", {sl811_cs_n, sl811_a0}, 2'b01);
    check("sldata_zd", zd, 8'h99);
    bus_end();

    // Interrupt merge
    sl811_intrq = 1'b1;
    io_wr(16'h83AB, 8'h48);
    io_rd(16'h83AB, rd);
    check("rstint_read", rd, 8'hCA);
    check("rstint_model", rd, m_rstint());
    check("zint_low", zint_n, 0);
    io_wr(16'h83AB, 8'h08);
    check("zint_released", zint_n, 1);

    // USB control
    io_wr(16'h81AB, 8'h00);
    check("ms_n_high", sl811_ms_n, 1);
    usb_power = 1'b1;
    repeat (3) @(negedge fclk);
    io_rd(16'h81AB, rd);
    check("usbctl_power", rd, 8'h02);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          w = 8'($urandom);
          io_wr(16'h82AB, w);
          io_rd(16'h82AB, rd);
          check("r_wcfg", rd, m_wcfg);
          d = 8'($urandom);
          io_wr(16'h81AB, d);
          io_rd(16'h81AB, rd);
          check("r_usbctl", rd, m_ms + (usb_power ? 2 : 0));
          check("r_ms_n", sl811_ms_n, (m_ms == 1) ? 0 : 1);
        end
        1: begin
          w5300_int_n = 1'($urandom);
          sl811_intrq = 1'($urandom);
          usb_power   = 1'($urandom);
          d = 8'($urandom);
          io_wr(16'h83AB, d);
          io_rd(16'h83AB, rd);
          check("r_rstint", rd, m_rstint());
          check("r_zint", zint_n, m_zint());
          check("r_rst_n", {w5300_rst_n, sl811_rst_n}, m_wrst * 2 + m_slrst);
        end
        2: begin
          w = 8'($urandom);
          io_wr(16'h82AB, w);
          a = 16'($urandom);
          if ($urandom_range(0, 2) != 0) a[15:14] = w[1:0];
          zcsrom_n = ($urandom_range(0, 3) == 0);
          wr = 1'($urandom);
          d = 8'($urandom);
          hit = (((m_wcfg / 4) % 2) == 1) && !zcsrom_n && ((int'(a) / 'h4000) == m_wcfg % 4);
          bus_start(1'b0, wr, a, d);
          check("r_mem_blk", zblkrom, hit);
          check("r_mem_cs", {w5300_cs_n, sl811_cs_n, ziorqge}, {!hit, 1'b1, 1'b0});
          if (hit) begin
            check("r_mem_addr", w5300_addr, exp_win_addr(m_wcfg, int'(a)));
            if (wr) check("r_mem_wr", {bwr_n, brd_n, bd}, {2'b01, d});
            else check("r_mem_rd", {bwr_n, brd_n, zd}, {2'b10, d});
          end else begin
            check("r_mem_idle", {bwr_n, brd_n}, 2'b11);
          end
          bus_end();
          zcsrom_n = 1'b1;
        end
        default: begin
          w = 8'($urandom);
          io_wr(16'h82AB, w);
          a = {1'b0, 7'($urandom), 8'hAB};
          wr = 1'($urandom);
          d = 8'($urandom);
          bus_start(1'b1, wr, a, d);
          check("r_io_ge", ziorqge, 1);
          if (((m_wcfg / 16) % 2) == 1) begin
            check("r_io_wcs", {w5300_cs_n, sl811_cs_n}, 2'b01);
            check("r_io_waddr", w5300_addr, exp_port_addr(m_wcfg, int'(a)));
          end else begin
            check("r_io_scs", {w5300_cs_n, sl811_cs_n, sl811_a0}, 3'b101);
          end
          if (wr) check("r_io_wr", {bwr_n, bd}, {1'b0, d});
          else check("r_io_rd", {brd_n, zd}, {1'b0, d});
          bus_end();
        end
      endcase
    end

    // Reset overrides a concurrent register write
    @(negedge fclk);
    zrst_n = 1'b0;
    bus_start(1'b1, 1'b1, 16'h82AB, 8'hFF);
    bus_end();
    zrst_n = 1'b1;
    m_reset();
    repeat (3) @(negedge fclk);
    io_rd(16'h82AB, rd);
    check("rstovr_wcfg", rd, 8'h00);
    io_rd(16'h83AB, rd);
    check("rstovr_rstint", rd, m_rstint());
    check("rstovr_ms_n", sl811_ms_n, 0);
    check("rstovr_zint", zint_n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
